// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sample transmit/receive paths.
//   SAMPLE_W       : sample width shared with the receive path and signal_processor
//   spi_tx_state_t : transmitter FSM states
//   tmr_width()    : width of the shared half-period/gap down-counter
package spi_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } spi_tx_state_t;

  // clog2 of the largest interval the timer must hold, never less than 1 bit
  // so that HALF_PER == CS_GAP == 1 still yields a legal vector.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter with a done flag. Loading N-1 makes the owner stay
// in a state for exactly N cycles: done is high on the last of them.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : synchronous active-low reset
//   i_load     : load i_load_val this cycle (has priority over counting)
//   i_load_val : value to load
//   o_done     : counter is at zero
module spi_phase_timer #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)           r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/spi_sample_transmitter.sv
// SPI master (mode 0, MSB first) that serialises samples to the DAC/codec.
// A one-entry holding buffer gives one frame of lookahead.
// Ports:
//   input_clk  : system clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   in_data    : sample to transmit
//   in_valid   : in_data valid
//   in_ready   : holding buffer empty; accept on in_valid && in_ready
//   cs_n       : chip select, active low
//   sclk       : serial clock (idle low)
//   mosi       : serial data, changes on sclk falling edge
//   busy       : FSM not in IDLE
//   frame_done : one-cycle pulse on the cycle cs_n returns high
module spi_sample_transmitter
  import spi_pkg::*;
#(
  parameter int DATA_W   = SAMPLE_W,
  parameter int HALF_PER = 2,
  parameter int CS_GAP   = 2
) (
  input  logic              input_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  output logic              busy,
  output logic              frame_done
);

  localparam int TMR_W = tmr_width(HALF_PER, CS_GAP);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TMR_W-1:0] HALF_LD  = TMR_W'(HALF_PER - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_tx_state_t     r_state;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_full;
  logic              r_in_ready;
  logic              r_cs_n;
  logic              r_sclk;
  logic              r_busy;
  logic              r_frame_done;

  logic              w_accept;
  logic              w_drain;
  logic              w_tmr_load;
  logic              w_tmr_done;
  logic [TMR_W-1:0]  w_tmr_val;

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = (r_state == IDLE) && r_full;

  // Every timed state exits when the timer reaches zero, so reloading on
  // done (plus continuously in IDLE) reloads on every state entry. Only the
  // TRAIL exit enters GAP; every other entry is a half-period state.
  assign w_tmr_load = (r_state == IDLE) || w_tmr_done;
  assign w_tmr_val  = (r_state == TRAIL) ? GAP_LD : HALF_LD;

  spi_phase_timer #(.W(TMR_W)) u_timer (
    .i_clk      (input_clk),
    .i_rst_n    (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // Holding buffer. Accept and drain never coincide: accept needs the buffer
  // empty (in_ready high), drain needs it full.
  always_ff @(posedge input_clk) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_full     <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (w_accept) begin
      r_buf      <= in_data;
      r_full     <= 1'b1;
      r_in_ready <= 1'b0;
    end else if (w_drain) begin
      r_full     <= 1'b0;
      r_in_ready <= 1'b1;
    end
  end

  // Frame FSM. mosi is the shift register MSB, so clearing the shift
  // register on the way into GAP also returns mosi to 0.
  always_ff @(posedge input_clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_cs_n       <= 1'b1;
      r_sclk       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_full) begin
            r_shift   <= r_buf;
            r_bit_cnt <= LAST_BIT;
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= LEAD;
          end
        end
        LEAD: begin
          if (w_tmr_done) begin
            r_sclk  <= 1'b1;
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (w_tmr_done) begin
            r_sclk <= 1'b0;
            if (r_bit_cnt == '0) begin
              r_state <= TRAIL;
            end else begin
              r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 1'b1;
              r_state   <= LOW;
            end
          end
        end
        LOW: begin
          if (w_tmr_done) begin
            r_sclk  <= 1'b1;
            r_state <= HIGH;
          end
        end
        TRAIL: begin
          if (w_tmr_done) begin
            r_cs_n       <= 1'b1;
            r_shift      <= '0;
            r_frame_done <= 1'b1;
            r_state      <= GAP;
          end
        end
        GAP: begin
          if (w_tmr_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign cs_n       = r_cs_n;
  assign sclk       = r_sclk;
  assign mosi       = r_shift[DATA_W-1];
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_spi_sample_transmitter.sv
// Bench: two instances (default timing, and HALF_PER=CS_GAP=1). Stimulus
// pushes each accepted word into a scoreboard; a negedge monitor rebuilds
// frames from the SPI pins and compares against the popped entry.
module tb_spi_sample_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0][15:0] in_data;
  logic [1:0]      in_valid;

  logic in_ready0, cs_n0, sclk0, mosi0, busy0, fd0;
  logic in_ready1, cs_n1, sclk1, mosi1, busy1, fd1;
  wire [1:0] in_ready   = {in_ready1, in_ready0};
  wire [1:0] cs_n       = {cs_n1, cs_n0};
  wire [1:0] sclk       = {sclk1, sclk0};
  wire [1:0] mosi       = {mosi1, mosi0};
  wire [1:0] busy       = {busy1, busy0};
  wire [1:0] frame_done = {fd1, fd0};

  spi_sample_transmitter #(.DATA_W(16), .HALF_PER(2), .CS_GAP(2)) u_dut0 (
    .input_clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready0), .cs_n(cs_n0), .sclk(sclk0), .mosi(mosi0),
    .busy(busy0), .frame_done(fd0));

  spi_sample_transmitter #(.DATA_W(16), .HALF_PER(1), .CS_GAP(1)) u_dut1 (
    .input_clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready1), .cs_n(cs_n1), .sclk(sclk1), .mosi(mosi1),
    .busy(busy1), .frame_done(fd1));

  typedef struct {
    int          id;
    logic [15:0] data;
    int          gap;   // expected cs_n-high run before the frame, 0 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_frames [2];
  int   frames     [2];
  bit   mon_en = 1'b0;

  // monitor state
  bit          in_fr     [2];
  int          low_n     [2];
  int          rises     [2];
  int          gap_run   [2];
  int          gap_start [2];
  int          cyc       [2];
  int          last_rise [2];
  logic [15:0] word      [2];
  logic        prev_sclk [2];

  function automatic int hp_of(input int id);
    return (id == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(input int id);
    return (id == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Frame reconstruction from the pins, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int id = 0; id < 2; id++) begin
        cyc[id]++;
        if (!rst_n) begin
          in_fr[id]     = 1'b0;
          rises[id]     = 0;
          low_n[id]     = 0;
          gap_run[id]   = 0;
          prev_sclk[id] = 1'b0;
        end else begin
          if (cs_n[id] === 1'b0) begin
            if (!in_fr[id]) begin
              in_fr[id]     = 1'b1;
              gap_start[id] = gap_run[id];
              low_n[id]     = 0;
              rises[id]     = 0;
              word[id]      = '0;
            end
            gap_run[id] = 0;
            low_n[id]++;
            chk("busy_in_frame", 32'(busy[id]), 32'd1);
            if (sclk[id] && !prev_sclk[id]) begin
              if (rises[id] > 0)
                chk("sclk_period", 32'(cyc[id] - last_rise[id]), 32'(2 * hp_of(id)));
              last_rise[id] = cyc[id];
              rises[id]++;
              word[id] = {word[id][14:0], mosi[id]};
            end
          end else begin
            gap_run[id]++;
            chk("idle_sclk", 32'(sclk[id]), 32'd0);
            chk("idle_mosi", 32'(mosi[id]), 32'd0);
          end
          if (frame_done[id] === 1'b1) begin
            frames[id]++;
            if (exp_q.size() == 0) begin
              chk("unexpected_frame_done", 32'(id), 32'hFFFF_FFFF);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              chk("frame_dut", 32'(id), 32'(e.id));
              chk("frame_word", 32'(word[id]), 32'(e.data));
              chk("sclk_rises", 32'(rises[id]), 32'd16);
              chk("cs_low_len", 32'(low_n[id]), 32'(33 * hp_of(id)));
              chk("frame_done_cs", 32'(cs_n[id]), 32'd1);
              if (e.gap != 0) chk("cs_gap", 32'(gap_start[id]), 32'(e.gap));
            end
            in_fr[id] = 1'b0;
          end
          prev_sclk[id] = sclk[id];
        end
      end
    end
  end

  // Called just after a falling edge. Waits for in_ready, records the
  // expectation, and returns on the falling edge after the accepting edge.
  task automatic send(input int id, input logic [15:0] d, input bit keep_valid, input int gap);
    int t;
    exp_t e;
    t = 0;
    in_data[id]  = d;
    in_valid[id] = 1'b1;
    while (in_ready[id] !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      chk("send_timeout", 32'(t), 32'd0);
      in_valid[id] = 1'b0;
      return;
    end
    e.id = id; e.data = d; e.gap = gap;
    exp_q.push_back(e);
    exp_frames[id]++;
    @(negedge clk);
    chk("ready_drop", 32'(in_ready[id]), 32'd0);
    if (!keep_valid) in_valid[id] = 1'b0;
  endtask

  task automatic wait_idle(input int extra);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (extra) @(negedge clk);
  endtask

  initial begin
    int t;
    int ready_seen;
    logic [15:0] d;
    rst_n    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    repeat (3) @(negedge clk);

    // reset state on both instances
    for (int id = 0; id < 2; id++) begin
      chk("rst_cs_n", 32'(cs_n[id]), 32'd1);
      chk("rst_sclk", 32'(sclk[id]), 32'd0);
      chk("rst_mosi", 32'(mosi[id]), 32'd0);
      chk("rst_ready", 32'(in_ready[id]), 32'd1);
      chk("rst_busy", 32'(busy[id]), 32'd0);
      chk("rst_frame_done", 32'(frame_done[id]), 32'd0);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // single frame, plus load latency from an idle block
    send(0, 16'hA5C3, 1'b0, 0);
    chk("lead_cs_still_high", 32'(cs_n[0]), 32'd1);
    @(negedge clk);
    chk("lead_cs_low", 32'(cs_n[0]), 32'd0);
    chk("ready_reloaded", 32'(in_ready[0]), 32'd1);
    wait_idle(10);

    // constant-data frames
    send(0, 16'h0000, 1'b0, 0);
    wait_idle(5);
    send(0, 16'hFFFF, 1'b0, 0);
    wait_idle(5);

    // back-to-back with in_valid held high
    send(0, 16'h1234, 1'b1, 0);
    send(0, 16'h8001, 1'b0, gap_of(0) + 1);
    wait_idle(10);

    // new data offered while the buffer is full must be ignored
    send(0, 16'h5A0F, 1'b1, 0);
    send(0, 16'hC3A5, 1'b1, gap_of(0) + 1);
    in_data[0] = 16'hDEAD;
    ready_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready[0] !== 1'b0) ready_seen++;
    end
    chk("hold_no_accept", 32'(ready_seen), 32'd0);
    in_valid[0] = 1'b0;
    wait_idle(120);

    // randomized traffic
    for (int i = 0; i < 12; i++) begin
      bit keep;
      d    = 16'($urandom);
      keep = (i != 11) && ($urandom_range(0, 1) == 1);
      send(0, d, keep, 0);
      if (!keep) repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_idle(10);

    // reset in the middle of a frame
    send(0, 16'hFFFF, 1'b0, 0);
    t = 0;
    while (rises[0] < 5 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("reach_5th_rise", 32'(t < 500), 32'd1);
    #1;
    rst_n = 1'b0;
    exp_frames[0] -= exp_q.size();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_cs_n", 32'(cs_n[0]), 32'd1);
    chk("abort_sclk", 32'(sclk[0]), 32'd0);
    chk("abort_mosi", 32'(mosi[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_ready", 32'(in_ready[0]), 32'd1);
    chk("abort_frame_done", 32'(frame_done[0]), 32'd0);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    send(0, 16'h3C5A, 1'b0, 0);
    wait_idle(10);

    // fastest timing instance
    send(1, 16'h8000, 1'b0, 0);
    wait_idle(5);
    send(1, 16'h6B21, 1'b1, 0);
    send(1, 16'h0001, 1'b0, gap_of(1) + 1);
    wait_idle(20);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frames_dut0", 32'(frames[0]), 32'(exp_frames[0]));
    chk("frames_dut1", 32'(frames[1]), 32'(exp_frames[1]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
